spi_byte_rx: RTL and testbench

//  SPI mode-0 slave front end, oversampled in the clk_i domain. Synchronises raw

---
 rtl/spi_byte_rx.sv | 146 ++++++++++++++
 tb/tb_spi_byte_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: SPI mode-0 slave byte receiver with MISO readback.
// Pins are synchronised into clk_i and SCLK/CS edges are detected there.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_dc_i,
    input  logic [7:0] tx_byte_data_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic       spi_byte_vld_o,
    output logic [7:0] spi_byte_data_o,
    output logic       dc_o,
    output logic       byte_abort_o
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic [SYNC_STAGES-1:0] dc_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;
    logic dc_s;
    logic sclk_d;
    logic cs_n_d;

    logic rise;
    logic fall;
    logic cs_fall;
    logic cs_rise;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic       load_pend;

    // Pin synchronisers, reset to the idle pin levels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_n_q <= '1;
            dc_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
            cs_n_q <= {cs_n_q[SYNC_STAGES-2:0], spi_cs_n_i};
            dc_q   <= {dc_q[SYNC_STAGES-2:0], spi_dc_i};
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
    assign cs_n_s = cs_n_q[SYNC_STAGES-1];
    assign dc_s   = dc_q[SYNC_STAGES-1];

    // Delayed copies of SCLK and CS for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_d <= 1'b0;
            cs_n_d <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_n_d <= cs_n_s;
        end
    end

    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = ~cs_n_s & cs_n_d;
    assign cs_rise = cs_n_s & ~cs_n_d;

    // Frame FSM: shift in on SCLK rise, shift out on SCLK fall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            bit_cnt         <= 3'd0;
            rx_sr           <= 7'd0;
            tx_sr           <= 8'd0;
            load_pend       <= 1'b0;
            spi_miso_oe_o   <= 1'b0;
            spi_byte_vld_o  <= 1'b0;
            spi_byte_data_o <= 8'h00;
            dc_o            <= 1'b0;
            byte_abort_o    <= 1'b0;
        end else begin
            spi_byte_vld_o <= 1'b0;
            byte_abort_o   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        bit_cnt       <= 3'd0;
                        tx_sr         <= tx_byte_data_i;
                        load_pend     <= 1'b0;
                        spi_miso_oe_o <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state         <= IDLE;
                        bit_cnt       <= 3'd0;
                        load_pend     <= 1'b0;
                        spi_miso_oe_o <= 1'b0;
                        byte_abort_o  <= (bit_cnt != 3'd0);
                    end else begin
                        if (rise) begin
                            rx_sr   <= {rx_sr[5:0], mosi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                spi_byte_data_o <= {rx_sr, mosi_s};
                                dc_o            <= dc_s;
                                spi_byte_vld_o  <= 1'b1;
                                load_pend       <= 1'b1;
                            end
                        end
                        if (fall) begin
                            if (load_pend) begin
                                tx_sr     <= tx_byte_data_i;
                                load_pend <= 1'b0;
                            end else begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi_miso_o = tx_sr[7];

endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: directed and random SPI frames against a byte scoreboard.
// Expected bytes, DC flags and strobe cycles come from what the bench drives.
module tb_spi_byte_rx;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       dc;
    logic [7:0] tx_data;
    logic       miso;
    logic       miso_oe;
    logic       vld;
    logic [7:0] bdata;
    logic       dco;
    logic       abort;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int abort_cnt = 0;
    int last_rise = 0;
    logic [7:0] miso_cap = 8'h00;

    logic [7:0] exp_data[$];
    logic       exp_dc[$];
    int         exp_cyc[$];
    logic [7:0] got_data[$];
    logic       got_dc[$];
    int         got_cyc[$];

    spi_byte_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .spi_sclk_i     (sclk),
        .spi_mosi_i     (mosi),
        .spi_cs_n_i     (cs_n),
        .spi_dc_i       (dc),
        .tx_byte_data_i (tx_data),
        .spi_miso_o     (miso),
        .spi_miso_oe_o  (miso_oe),
        .spi_byte_vld_o (vld),
        .spi_byte_data_o(bdata),
        .dc_o           (dco),
        .byte_abort_o   (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe cycle after the edge has settled
    always @(posedge clk) begin
        #1;
        if (vld === 1'b1) begin
            got_data.push_back(bdata);
            got_dc.push_back(dco);
            got_cyc.push_back(cyc);
        end
        if (abort === 1'b1) abort_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before rise
    task automatic send_byte(input logic [7:0] b, input int half,
                             input logic [7:0] tx_next, input logic d);
        dc = d;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            tick(half);
            miso_cap = {miso_cap[6:0], miso};
            sclk = 1'b1;
            if (i == 0) last_rise = cyc;
            tick(half);
            if (i == 0) tx_data = tx_next;
            sclk = 1'b0;
        end
        exp_data.push_back(b);
        exp_dc.push_back(d);
        exp_cyc.push_back(last_rise + 1 + SYNC);
    endtask

    task automatic send_partial(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            mosi = 1'($urandom);
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] o;
        chk({tag, "_count"}, got_data.size(), exp_data.size());
        while (exp_data.size() > 0) begin
            o = (got_data.size() > 0) ? 32'(got_data.pop_front()) : 'x;
            chk({tag, "_data"}, o, exp_data.pop_front());
            o = (got_dc.size() > 0) ? 32'(got_dc.pop_front()) : 'x;
            chk({tag, "_dc"}, o, exp_dc.pop_front());
            o = (got_cyc.size() > 0) ? 32'(got_cyc.pop_front()) : 'x;
            chk({tag, "_lat"}, o, exp_cyc.pop_front());
        end
        got_data.delete();
        got_dc.delete();
        got_cyc.delete();
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, "_vld"}, vld, 0);
        chk({tag, "_data"}, bdata, 0);
        chk({tag, "_dc"}, dco, 0);
        chk({tag, "_miso"}, miso, 0);
        chk({tag, "_oe"}, miso_oe, 0);
        chk({tag, "_abort"}, abort, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       d;
        rst = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        dc = 1'b0;
        tx_data = 8'hFF;
        tick(4);
        check_idle_outs("rst");
        rst = 1'b0;
        tick(4);

        // Reset mid-byte, then a clean byte
        cs_n = 1'b0;
        tick(8);
        send_partial(3, 4);
        rst = 1'b1;
        tick(3);
        check_idle_outs("midrst");
        rst = 1'b0;
        tick(8);
        chk("midrst_vldcnt", got_data.size(), 0);
        send_byte(8'hA5, 4, tx_data, 1'b0);
        cs_n = 1'b1;
        tick(8);
        check_bytes("t1");
        chk("t1_noabort", abort_cnt, 0);

        // Single command byte
        dc = 1'b0;
        cs_n = 1'b0;
        tick(8);
        send_byte(8'h3B, 4, tx_data, 1'b0);
        cs_n = 1'b1;
        tick(8);
        check_bytes("t2");

        // Data burst without CS toggle
        cs_n = 1'b0;
        tick(8);
        send_byte(8'h01, 4, tx_data, 1'b1);
        send_byte(8'h80, 4, tx_data, 1'b1);
        send_byte(8'hFF, 4, tx_data, 1'b1);
        cs_n = 1'b1;
        tick(8);
        check_bytes("t3");

        // Readback on MISO
        tx_data = 8'hC3;
        cs_n = 1'b0;
        tick(8);
        chk("t4_oe_on", miso_oe, 1);
        send_byte(8'h12, 8, 8'h5A, 1'b1);
        chk("t4_miso0", miso_cap, 8'hC3);
        send_byte(8'h34, 8, 8'h00, 1'b1);
        chk("t4_miso1", miso_cap, 8'h5A);
        cs_n = 1'b1;
        tick(8);
        chk("t4_oe_off", miso_oe, 0);
        check_bytes("t4");

        // Abort after 5 bits
        abort_cnt = 0;
        cs_n = 1'b0;
        tick(8);
        send_partial(5, 4);
        cs_n = 1'b1;
        tick(8);
        chk("t5_abort", abort_cnt, 1);
        chk("t5_novld", got_data.size(), 0);
        chk("t5_data", bdata, 8'h34);
        chk("t5_dc", dco, 1);
        chk("t5_oe", miso_oe, 0);

        // Random bytes at clk/4
        for (int s = 0; s < 4; s++) begin
            cs_n = 1'b0;
            tick(4);
            for (int k = 0; k < 5; k++) begin
                b = 8'($urandom);
                d = 1'($urandom);
                send_byte(b, 2, tx_data, d);
            end
            cs_n = 1'b1;
            tick(6);
        end
        tick(4);
        check_bytes("t6");
        chk("t6_noabort", abort_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
